// File: rtl/vic_wb_ctrl.sv
// Victim-cache write-back scheduler: buffers dirty evictions in a FIFO and
// arbitrates the memory bus between buffered stores and dcache miss loads.
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 5
`endif
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 8
`endif

module vic_wb_ctrl #(
  parameter int unsigned WR_PORTS   = 3,
  parameter int unsigned WB_DEPTH   = 8,
  parameter int unsigned HI_WATER   = 6,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned SET_BITS   = `NUM_SET_BITS,
  parameter int unsigned TAG_BITS   = `NUM_TAG_BITS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [WR_PORTS-1:0]                  evict_valid_i,
  input  logic [WR_PORTS-1:0]                  evict_dirty_i,
  input  logic [WR_PORTS-1:0][TAG_BITS-1:0]    evict_tag_i,
  input  logic [WR_PORTS-1:0][SET_BITS-1:0]    evict_idx_i,
  input  logic [WR_PORTS-1:0][63:0]            evict_data_i,
  input  logic                                 ld_req_i,
  input  logic [63:0]                          ld_addr_i,
  output logic                                 ld_grant_o,
  output logic [3:0]                           ld_tag_o,
  output logic [1:0]                           proc2mem_command_o,
  output logic [63:0]                          proc2mem_addr_o,
  output logic [63:0]                          proc2mem_data_o,
  input  logic [3:0]                           mem2proc_response_i,
  output logic [$clog2(WB_DEPTH):0]            wb_count_o,
  output logic                                 wb_stall_o,
  output logic                                 overflow_err_o
);

  localparam int unsigned PW  = $clog2(WB_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned SPW = CW + 1;
  localparam int unsigned SW  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WB   = 2'd1,
    BUS_LD   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [63:0]     addr_mem [WB_DEPTH];
  logic [63:0]     data_mem [WB_DEPTH];

  logic                         accept;
  logic                         pop;
  logic [CW-1:0]                avail;
  logic                         has_avail;
  logic                         decide;
  logic [WR_PORTS-1:0]          push_mask;
  logic [WR_PORTS-1:0]          push_en;
  logic [WR_PORTS-1:0][PW-1:0]  push_slot;
  logic [CW-1:0]                n_acc;
  logic [SPW-1:0]               space;
  logic                         drop;

  // Ports are packed into consecutive slots in ascending order; once space
  // runs out every remaining dirty port is dropped, so the highest go first.
  always_comb begin
    accept    = (mem2proc_response_i != 4'd0);
    pop       = (state_q == BUS_WB) && accept;
    push_mask = evict_valid_i & evict_dirty_i;
    space     = SPW'(WB_DEPTH) - SPW'(count_q) + SPW'(pop);
    n_acc     = '0;
    drop      = 1'b0;
    push_en   = '0;
    push_slot = '0;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      push_slot[p] = tail_q + PW'(n_acc);
      if (push_mask[p]) begin
        if (SPW'(n_acc) < space) begin
          push_en[p] = 1'b1;
          n_acc      = n_acc + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Decisions see only the registered occupancy minus this cycle's pop.
  always_comb begin
    avail     = count_q - CW'(pop);
    has_avail = (avail != '0);
    decide    = (state_q == BUS_IDLE) || pop;
    state_d   = state_q;
    starve_d  = starve_q;
    if (decide) begin
      if ((avail >= CW'(HI_WATER)) || ((starve_q == SW'(STARVE_MAX)) && has_avail)) begin
        state_d  = BUS_WB;
        starve_d = '0;
      end else if (ld_req_i) begin
        state_d = BUS_LD;
        if (has_avail && (starve_q != SW'(STARVE_MAX)))
          starve_d = starve_q + SW'(1);
      end else if (has_avail) begin
        state_d  = BUS_WB;
        starve_d = '0;
      end else begin
        state_d = BUS_IDLE;
      end
    end else if ((state_q == BUS_LD) && accept) begin
      state_d = BUS_IDLE;
    end
    if (!has_avail)
      starve_d = '0;

    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(n_acc);
    count_d = count_q - CW'(pop) + n_acc;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BUS_IDLE;
      starve_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      if (push_en[p]) begin
        addr_mem[push_slot[p]] <= 64'({evict_tag_i[p], evict_idx_i[p], 3'b000});
        data_mem[push_slot[p]] <= evict_data_i[p];
      end
    end
  end

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    case (state_q)
      BUS_WB: begin
        proc2mem_command_o = BUS_STORE;
        proc2mem_addr_o    = addr_mem[head_q];
        proc2mem_data_o    = data_mem[head_q];
      end
      BUS_LD: begin
        proc2mem_command_o = BUS_LOAD;
        proc2mem_addr_o    = ld_addr_i;
      end
      default: ;
    endcase
    ld_grant_o     = (state_q == BUS_LD) && accept;
    ld_tag_o       = ld_grant_o ? mem2proc_response_i : 4'd0;
    wb_count_o     = count_q;
    wb_stall_o     = (SPW'(WB_DEPTH) - SPW'(count_q)) < SPW'(WR_PORTS);
    overflow_err_o = ovf_q;
  end

endmodule

// File: tb/tb_vic_wb_ctrl.sv
// Directed bench for vic_wb_ctrl: a per-cycle vector table plus hand-written
// sequences for overflow/wrap, held stores, high water and mid-run reset.
module tb_vic_wb_ctrl;

  localparam logic [1:0]  C_N = 2'd0;
  localparam logic [1:0]  C_L = 2'd1;
  localparam logic [1:0]  C_S = 2'd2;
  localparam logic [63:0] LD_ADDR = 64'h0000_1234_5678_9AC0;

  typedef struct packed {
    logic [2:0] v;
    logic [2:0] d;
    logic [7:0] base;
    logic       ld;
    logic [3:0] resp;
    logic [1:0] cmd;
    logic [7:0] key;
    logic       grant;
    logic [3:0] cnt;
    logic       stall;
    logic       ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       evict_valid = '0;
  logic [2:0]       evict_dirty = '0;
  logic [2:0][7:0]  evict_tag = '0;
  logic [2:0][4:0]  evict_idx = '0;
  logic [2:0][63:0] evict_data = '0;
  logic             ld_req = 1'b0;
  logic [63:0]      ld_addr = LD_ADDR;
  logic             ld_grant;
  logic [3:0]       ld_tag;
  logic [1:0]       cmd;
  logic [63:0]      maddr;
  logic [63:0]      mdata;
  logic [3:0]       resp = '0;
  logic [3:0]       wb_count;
  logic             wb_stall;
  logic             overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vic_wb_ctrl #(
    .WR_PORTS(3), .WB_DEPTH(8), .HI_WATER(6), .STARVE_MAX(3),
    .SET_BITS(5), .TAG_BITS(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .evict_valid_i(evict_valid), .evict_dirty_i(evict_dirty),
    .evict_tag_i(evict_tag), .evict_idx_i(evict_idx), .evict_data_i(evict_data),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr),
    .ld_grant_o(ld_grant), .ld_tag_o(ld_tag),
    .proc2mem_command_o(cmd), .proc2mem_addr_o(maddr), .proc2mem_data_o(mdata),
    .mem2proc_response_i(resp),
    .wb_count_o(wb_count), .wb_stall_o(wb_stall), .overflow_err_o(overflow_err)
  );

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, got, want);
    end
  endtask

  task automatic check(input vec_t t, input string nm, input int idx);
    logic [63:0] ea, ed;
    logic [7:0]  k;
    k  = t.key;
    ea = (t.cmd == C_S) ? 64'({k, k[4:0], 3'b000}) : (t.cmd == C_L) ? LD_ADDR : 64'h0;
    ed = (t.cmd == C_S) ? {32'hDA7A_0000, 24'h0, k} : 64'h0;
    chk({nm, ".cmd"},   idx, 64'(cmd), 64'(t.cmd));
    chk({nm, ".addr"},  idx, maddr, ea);
    chk({nm, ".data"},  idx, mdata, ed);
    chk({nm, ".grant"}, idx, 64'(ld_grant), 64'(t.grant));
    chk({nm, ".tag"},   idx, 64'(ld_tag), t.grant ? 64'(t.resp) : 64'h0);
    chk({nm, ".count"}, idx, 64'(wb_count), 64'(t.cnt));
    chk({nm, ".stall"}, idx, 64'(wb_stall), 64'(t.stall));
    chk({nm, ".ovf"},   idx, 64'(overflow_err), 64'(t.ovf));
  endtask

  task automatic drive(input vec_t t);
    for (int p = 0; p < 3; p++) begin
      evict_tag[p]  = 8'(t.base + 8'(p));
      evict_idx[p]  = 5'(t.base + 8'(p));
      evict_data[p] = {32'hDA7A_0000, 24'h0, 8'(t.base + 8'(p))};
    end
    evict_valid = t.v;
    evict_dirty = t.d;
    ld_req      = t.ld;
    resp        = t.resp;
  endtask

  task automatic apply(input vec_t t, input string nm, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    check(t, nm, idx);
  endtask

  vec_t tbl [19];

  initial begin
    // v, d, base, ld, resp | cmd, key, grant, cnt, stall, ovf
    tbl[0]  = vec_t'{3'b111, 3'b101, 8'h10, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[2]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_S, 8'h10, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[3]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_S, 8'h12, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[4]  = vec_t'{3'b011, 3'b011, 8'h20, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h1, C_N, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[6]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h1, C_L, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[7]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h2, C_N, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[8]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h2, C_L, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[9]  = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h3, C_N, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[10] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h3, C_L, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[11] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h4, C_N, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[12] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h4, C_S, 8'h20, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[13] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h5, C_L, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[14] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h6, C_N, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[15] = vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h6, C_L, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[16] = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[17] = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_S, 8'h21, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[18] = vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};

    // Reset held with evictions and a load request active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(vec_t'{3'b111, 3'b111, 8'h70, 1'b1, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0});
      #1;
      check(vec_t'{3'b111, 3'b111, 8'h70, 1'b1, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0}, "rst", i);
    end
    drive(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) apply(tbl[i], "tbl", i);

    // Overflow: three dirty lines per cycle into a stalled bus.
    apply(vec_t'{3'b111, 3'b111, 8'h40, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0}, "ovf", 0);
    apply(vec_t'{3'b111, 3'b111, 8'h43, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd3, 1'b0, 1'b0}, "ovf", 1);
    apply(vec_t'{3'b111, 3'b111, 8'h46, 1'b0, 4'h0, C_S, 8'h40, 1'b0, 4'd6, 1'b1, 1'b0}, "ovf", 2);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_S, 8'h40, 1'b0, 4'd8, 1'b1, 1'b1}, "ovf", 3);
    for (int i = 0; i < 8; i++)
      apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_S, 8'(8'h40 + 8'(i)), 1'b0,
                   4'(8 - i), (i < 3), 1'b1}, "drain", i);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1}, "drain", 8);

    // Held store then accept with a nonzero non-one response.
    apply(vec_t'{3'b111, 3'b111, 8'h50, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1}, "held", 0);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd3, 1'b0, 1'b1}, "held", 1);
    for (int i = 0; i < 5; i++)
      apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_S, 8'h50, 1'b0, 4'd3, 1'b0, 1'b1}, "held", 2 + i);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h7, C_S, 8'h50, 1'b0, 4'd3, 1'b0, 1'b1}, "held", 7);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_S, 8'h51, 1'b0, 4'd2, 1'b0, 1'b1}, "held", 8);

    // High water: stores beat a pending load while avail >= 6.
    apply(vec_t'{3'b111, 3'b111, 8'h60, 1'b0, 4'h0, C_S, 8'h51, 1'b0, 4'd2, 1'b0, 1'b1}, "hiw", 0);
    apply(vec_t'{3'b011, 3'b011, 8'h63, 1'b0, 4'h0, C_S, 8'h51, 1'b0, 4'd5, 1'b0, 1'b1}, "hiw", 1);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'hF, C_S, 8'h51, 1'b0, 4'd7, 1'b1, 1'b1}, "hiw", 2);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'hF, C_S, 8'h52, 1'b0, 4'd6, 1'b1, 1'b1}, "hiw", 3);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b1, 4'h9, C_L, 8'h00, 1'b1, 4'd5, 1'b0, 1'b1}, "hiw", 4);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd5, 1'b0, 1'b1}, "hiw", 5);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_S, 8'h60, 1'b0, 4'd5, 1'b0, 1'b1}, "hiw", 6);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_S, 8'h61, 1'b0, 4'd4, 1'b0, 1'b1}, "hiw", 7);

    // Reset mid-store: command abandoned, buffered lines and sticky error lost.
    #1;
    rst_n = 1'b0;
    #1;
    check(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'h0, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0}, "rstmid", 0);
    @(negedge clk);
    drive(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0});
    #2;
    rst_n = 1'b1;
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0}, "rstmid", 1);
    apply(vec_t'{3'b000, 3'b000, 8'h00, 1'b0, 4'hF, C_N, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0}, "rstmid", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
